// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall controller.
// The controller takes the slave side; the stages (or a bench) take the master side.
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 6
);
   logic             id_stallreq;
   logic             ex_mc_start;
   logic [CNT_W-1:0] ex_mc_len;
   logic             mem_req;
   logic             mem_ack;
   logic             flush_req;
   logic [5:0]       stall;
   logic             flush;
   logic             ex_mc_done;
   logic             ex_mc_abort;
   logic             mem_timeout;
   logic [31:0]      stall_cycles;

   modport master (
      output id_stallreq, ex_mc_start, ex_mc_len, mem_req, mem_ack, flush_req,
      input  stall, flush, ex_mc_done, ex_mc_abort, mem_timeout, stall_cycles
   );

   modport slave (
      input  id_stallreq, ex_mc_start, ex_mc_len, mem_req, mem_ack, flush_req,
      output stall, flush, ex_mc_done, ex_mc_abort, mem_timeout, stall_cycles
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: EX multi-cycle sequencing and MEM wait timeout.
// Define PIPE_STALL_PERF_EN to build the stall_cycles performance counter; otherwise it reads 0.
module pipe_stall_ctrl #(
   parameter int CNT_W       = 6,
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 7
) (
   input logic               clk_i,
   input logic               rst_ni,
   pipe_stall_ctrl_if.slave  bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       ex_state_q, ex_state_d;
   logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d;
   logic [TO_W-1:0]  mem_cnt_q, mem_cnt_d;
   logic             mem_timeout_q;

   logic       mem_stall;
   logic       timeout_hit;
   logic       flush_any;
   logic       ex_stall;
   logic       mc_done;
   logic       mc_abort;
   logic [5:0] stall_vec;

   assign mem_stall   = bus.mem_req & ~bus.mem_ack;
   assign timeout_hit = mem_stall && (mem_cnt_q == TO_W'(MEM_TIMEOUT - 1));
   assign flush_any   = bus.flush_req | timeout_hit;

   // A MEM stall freezes the EX countdown and also holds off completion,
   // so the op always finishes exactly as many cycles late as MEM stalled it.
   always_comb begin
      ex_state_d = ex_state_q;
      ex_cnt_d   = ex_cnt_q;
      ex_stall   = 1'b0;
      mc_done    = 1'b0;
      mc_abort   = 1'b0;
      if (flush_any) begin
         ex_state_d = IDLE;
         ex_cnt_d   = '0;
         mc_abort   = (ex_state_q == BUSY);
      end else if (ex_state_q == IDLE) begin
         if (bus.ex_mc_start) begin
            if (bus.ex_mc_len >= CNT_W'(2)) begin
               ex_stall   = 1'b1;
               ex_state_d = BUSY;
               ex_cnt_d   = bus.ex_mc_len - CNT_W'(2);
            end else begin
               mc_done = 1'b1;
            end
         end
      end else if (ex_cnt_q != '0) begin
         ex_stall = 1'b1;
         if (!mem_stall) begin
            ex_cnt_d = ex_cnt_q - CNT_W'(1);
         end
      end else if (!mem_stall) begin
         mc_done    = 1'b1;
         ex_state_d = IDLE;
      end
   end

   always_comb begin
      stall_vec = 6'b000000;
      if (flush_any) begin
         stall_vec = 6'b000000;
      end else if (mem_stall) begin
         stall_vec = 6'b011111;
      end else if (ex_stall) begin
         stall_vec = 6'b001111;
      end else if (bus.id_stallreq) begin
         stall_vec = 6'b000111;
      end
   end

   assign mem_cnt_d = (flush_any || !mem_stall) ? '0 : mem_cnt_q + TO_W'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_state_q    <= IDLE;
         ex_cnt_q      <= '0;
         mem_cnt_q     <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         ex_state_q    <= ex_state_d;
         ex_cnt_q      <= ex_cnt_d;
         mem_cnt_q     <= mem_cnt_d;
         mem_timeout_q <= timeout_hit;
      end
   end

   // Combinational outputs are held low while reset is asserted.
   assign bus.stall       = rst_ni ? stall_vec : 6'b000000;
   assign bus.flush       = rst_ni & flush_any;
   assign bus.ex_mc_done  = rst_ni & mc_done;
   assign bus.ex_mc_abort = rst_ni & mc_abort;
   assign bus.mem_timeout = mem_timeout_q;

`ifdef PIPE_STALL_PERF_EN
   logic [31:0] stall_cycles_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cycles_q <= 32'h0;
      end else if (stall_vec != 6'b000000) begin
         stall_cycles_q <= stall_cycles_q + 32'h1;
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
`else
   assign bus.stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vectors plus a per-cycle reference model
// that tracks the EX op as an absolute completion cycle pushed back by MEM stalls.
module tb_pipe_stall_ctrl;

   localparam int CNT_W       = 6;
   localparam int MEM_TIMEOUT = 64;
   localparam int TO_W        = 7;
`ifdef PIPE_STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_stall_ctrl #(
      .CNT_W(CNT_W),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TO_W(TO_W)
   ) dut (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (bus)
   );

   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: an active op is a completion cycle number, not a countdown.
   bit          mBusy = 1'b0;
   int          mDoneAt = 0;
   int          mWait = 0;
   bit          mToPrev = 1'b0;
   int unsigned mPerf = 0;
   int          cyc = 0;
   bit          nBusy;
   int          nDoneAt;
   int          nWait;
   bit          nToPrev;
   int unsigned nPerf;

   always @(negedge clk) begin
      logic       memStall, toHit, eFlush, eExStall, eDone, eAbort;
      logic [5:0] eStall;
      if (!rstN) begin
         compare("model_rst_stall", bus.stall, 0);
         compare("model_rst_flush", bus.flush, 0);
         compare("model_rst_done", bus.ex_mc_done, 0);
         compare("model_rst_abort", bus.ex_mc_abort, 0);
         compare("model_rst_timeout", bus.mem_timeout, 0);
         compare("model_rst_perf", bus.stall_cycles, 0);
         nBusy = 1'b0; nDoneAt = 0; nWait = 0; nToPrev = 1'b0; nPerf = 0;
      end else begin
         memStall = bus.mem_req & ~bus.mem_ack;
         toHit    = memStall && (mWait == MEM_TIMEOUT - 1);
         eFlush   = bus.flush_req | toHit;
         eExStall = 1'b0; eDone = 1'b0; eAbort = 1'b0;
         nBusy    = mBusy; nDoneAt = mDoneAt;
         if (eFlush) begin
            eAbort = mBusy;
            nBusy  = 1'b0;
         end else if (mBusy) begin
            if (cyc < mDoneAt) begin
               eExStall = 1'b1;
            end else if (!memStall) begin
               eDone = 1'b1;
               nBusy = 1'b0;
            end
            if (memStall) nDoneAt = mDoneAt + 1;
         end else if (bus.ex_mc_start) begin
            if (int'(bus.ex_mc_len) >= 2) begin
               eExStall = 1'b1;
               nBusy    = 1'b1;
               nDoneAt  = cyc + int'(bus.ex_mc_len) - 1;
            end else begin
               eDone = 1'b1;
            end
         end
         eStall = eFlush ? 6'h00 : memStall ? 6'h1F : eExStall ? 6'h0F : bus.id_stallreq ? 6'h07 : 6'h00;
         compare("model_stall", bus.stall, eStall);
         compare("model_flush", bus.flush, eFlush);
         compare("model_done", bus.ex_mc_done, eDone);
         compare("model_abort", bus.ex_mc_abort, eAbort);
         compare("model_timeout", bus.mem_timeout, mToPrev);
         compare("model_perf", bus.stall_cycles, mPerf);
         nWait   = (eFlush || !memStall) ? 0 : mWait + 1;
         nToPrev = toHit;
         nPerf   = mPerf + ((PERF && eStall != 6'h00) ? 1 : 0);
      end
   end

   always @(posedge clk) begin
      if (!rstN) begin
         mBusy = 1'b0; mDoneAt = 0; mWait = 0; mToPrev = 1'b0; mPerf = 0;
      end else begin
         mBusy = nBusy; mDoneAt = nDoneAt; mWait = nWait; mToPrev = nToPrev; mPerf = nPerf;
      end
      cyc++;
   end

   task automatic applyStimulus(input logic id, input logic start, input logic [CNT_W-1:0] len,
                                input logic req, input logic ack, input logic fl);
      @(posedge clk);
      #1;
      bus.id_stallreq = id;
      bus.ex_mc_start = start;
      bus.ex_mc_len   = len;
      bus.mem_req     = req;
      bus.mem_ack     = ack;
      bus.flush_req   = fl;
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [5:0] expStall, input logic expFlush,
                              input logic expDone, input logic expAbort);
      compare({name, "_stall"}, bus.stall, expStall);
      compare({name, "_flush"}, bus.flush, expFlush);
      compare({name, "_done"}, bus.ex_mc_done, expDone);
      compare({name, "_abort"}, bus.ex_mc_abort, expAbort);
   endtask

   initial begin
      bus.id_stallreq = 1'b0;
      bus.ex_mc_start = 1'b0;
      bus.ex_mc_len   = '0;
      bus.mem_req     = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.flush_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("reset", 6'h00, 0, 0, 0);
      compare("reset_timeout", bus.mem_timeout, 0);
      compare("reset_perf", bus.stall_cycles, 0);

      // 5-cycle op with a concurrent load-use request: EX wins.
      applyStimulus(1, 1, 5, 0, 0, 0);
      checkOutput("ex5_c0", 6'h0F, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput("ex5_busy", 6'h0F, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("ex5_done", 6'h00, 0, 1, 0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
         checkOutput("mem_wait", 6'h1F, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("mem_ack", 6'h00, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      compare("perf_seven", bus.stall_cycles, PERF ? 32'd7 : 32'd0);

      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("id_stall", 6'h07, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("id_release", 6'h00, 0, 0, 0);

      // MEM stall while ex_cnt=2: completion slips by exactly three cycles.
      applyStimulus(0, 1, 5, 0, 0, 0);
      checkOutput("exmem_c0", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("exmem_c1", 6'h0F, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
         checkOutput("exmem_wait", 6'h1F, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("exmem_c5", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("exmem_c6", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("exmem_done", 6'h00, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("exmem_idle", 6'h00, 0, 0, 0);

      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("len1", 6'h00, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("len0", 6'h00, 0, 1, 0);
      applyStimulus(0, 1, 2, 0, 0, 0);
      checkOutput("len2_c0", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("len2_done", 6'h00, 0, 1, 0);

      applyStimulus(0, 1, 8, 0, 0, 0);
      checkOutput("fl8_c0", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fl8_c1", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("fl8_flush", 6'h00, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fl8_after", 6'h00, 0, 0, 0);

      applyStimulus(0, 1, 8, 0, 0, 1);
      checkOutput("fl_start", 6'h00, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fl_start_after", 6'h00, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("fl_id", 6'h00, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 1);
      checkOutput("fl_mem", 6'h00, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
         checkOutput("to_wait", (i == MEM_TIMEOUT - 1) ? 6'h00 : 6'h1F, i == MEM_TIMEOUT - 1, 0, 0);
         compare("to_no_pulse", bus.mem_timeout, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      compare("to_pulse", bus.mem_timeout, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      compare("to_pulse_end", bus.mem_timeout, 0);

      applyStimulus(0, 1, 8, 0, 0, 0);
      checkOutput("rst_op_c0", 6'h0F, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_op_c1", 6'h0F, 0, 0, 0);
      @(posedge clk);
      #1 rstN = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_mid", 6'h00, 0, 0, 0);
      @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst_after", 6'h00, 0, 0, 0);
      compare("rst_after_perf", bus.stall_cycles, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_idle", 6'h00, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Collects stall requests from ID (load-use hazard), EX (multi-cycle MULT/DIV unit) and MEM (bus wait), plus flush requests from the exception unit.
- Drives the per-stage `stall` vector consumed by `pc_reg` and every pipeline register (`if_id`, `id_ex`, `ex_mem`, `mem_wb`).
- Sequences multi-cycle EX operations and bounds MEM bus waits with a timeout.

Parameters:
- CNT_W, 6, width of the multi-cycle length input and its internal down-counter.
- MEM_TIMEOUT, 64, number of consecutive MEM wait cycles before the timeout flush.
- TO_W, 7, width of the MEM wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_stallreq  in  1  load-use hazard detected in ID.
- ex_mc_start  in  1  single-cycle pulse: a multi-cycle op enters EX this cycle.
- ex_mc_len  in  CNT_W  total EX occupancy of that op, in cycles.
- mem_req  in  1  MEM stage has an outstanding bus access.
- mem_ack  in  1  bus completes the access this cycle.
- flush_req  in  1  exception/eret flush request.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  out  1  clear all pipeline registers this cycle.
- ex_mc_done  out  1  multi-cycle result is valid in EX this cycle.
- ex_mc_abort  out  1  in-flight multi-cycle op is cancelled.
- mem_timeout  out  1  registered one-cycle pulse: MEM wait exceeded MEM_TIMEOUT.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - ex_state=IDLE, ex_cnt=0, mem_cnt=0, mem_timeout=0, stall_cycles=0.
  - Combinational outputs are forced to 0 while rst is low.
- stall, flush, ex_mc_done and ex_mc_abort are combinational from state and inputs. Only mem_timeout and stall_cycles are registered.
- Stall sources:
  - mem_stall = mem_req & ~mem_ack.
  - ex_stall is defined by the EX FSM below.
  - id_stall = id_stallreq.
- Stall encoding, highest priority first:
  - flush=1 gives stall=000000.
  - mem_stall gives 011111.
  - ex_stall gives 001111.
  - id_stall gives 000111.
  - Otherwise 000000.
- flush = flush_req | timeout_hit, where timeout_hit = mem_stall & (mem_cnt == MEM_TIMEOUT-1).
- EX FSM states: IDLE, BUSY.
  - IDLE, ex_mc_start, ex_mc_len >= 2: ex_stall=1 this cycle; next state BUSY with ex_cnt = ex_mc_len-2.
  - IDLE, ex_mc_start, ex_mc_len 0 or 1: single-cycle op; ex_mc_done=1 this cycle; no stall; stay IDLE.
  - BUSY, ex_cnt != 0: ex_stall=1. ex_cnt decrements unless mem_stall=1, in which case it is frozen.
  - BUSY, ex_cnt == 0: ex_stall=0, ex_mc_done=1, next state IDLE. If mem_stall=1 in this cycle, hold BUSY and suppress done until mem_stall drops.
  - ex_mc_start while in BUSY is ignored; it is illegal because ID/EX is stalled.
- MEM wait counter:
  - Increments on each mem_stall cycle; clears to 0 on any cycle with mem_stall=0.
  - On timeout_hit: mem_timeout pulses 1 in the next cycle and mem_cnt clears.
- Flush, from flush_req or timeout_hit, any state:
  - ex_state goes to IDLE and ex_cnt to 0.
  - ex_mc_abort=1 if ex_state was BUSY.
  - ex_mc_done is suppressed.
  - mem_cnt clears.
  - id_stallreq is ignored that cycle.
- Simultaneous flush_req and ex_mc_start: flush wins; the op never starts and abort=0.
- Reset asserted mid-operation aborts everything silently; no ex_mc_abort pulse.
- ex_mc_len is sampled only in the ex_mc_start cycle.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined:
  - stall_cycles increments by 1 on every cycle with stall != 0.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset only.
- Undefined: stall_cycles is tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Reset release, all inputs 0 -> stall=000000, flush=0, ex_mc_done=0, mem_timeout=0, stall_cycles=0.
- id_stallreq=1 for 1 cycle -> stall=000111 that cycle only.
- ex_mc_start with ex_mc_len=5 -> stall=001111 for cycles 0–3, ex_mc_done=1 with stall=000000 at cycle 4, FSM back in IDLE.
- ex_mc_len=5 and id_stallreq=1 concurrently -> stall=001111 (EX wins).
- mem_req=1 with mem_ack=0 for 3 cycles, then mem_ack=1 -> stall=011111 for 3 cycles, 000000 on the ack cycle. Same while the EX op is BUSY with ex_cnt=2 -> counter frozen, EX completes 3 cycles late.
- mem_req=1, mem_ack never arrives, MEM_TIMEOUT=64 -> flush=1 at wait cycle 64, mem_timeout=1 the next cycle.
- flush_req at cycle 2 of an ex_mc_len=8 op -> flush=1, ex_mc_abort=1, stall=000000, FSM IDLE, no ex_mc_done.
- With PIPE_STALL_PERF_EN: the 5-cycle op plus a 3-cycle MEM wait gives stall_cycles=7. Without the macro: stall_cycles stays 0.
